// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB3-Lite word-organised SRAM responder with byte lanes, wait states and ERROR responses
module ahb3lite_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sHSEL,
  input  logic [31:0] sHADDR,
  input  logic [31:0] sHWDATA,
  output logic [31:0] sHRDATA,
  input  logic        sHWRITE,
  input  logic [2:0]  sHSIZE,
  input  logic [2:0]  sHBURST,
  input  logic [3:0]  sHPROT,
  input  logic [1:0]  sHTRANS,
  output logic        sHREADYOUT,
  input  logic        sHREADY,
  output logic        sHRESP
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            hready_q, hready_d, hresp_q, hresp_d;
  logic            wr_q;
  logic [AW-1:0]   idx_q, idx_in;
  logic [3:0]      mask_q, mask_in, fwd_mask_q;
  logic [31:0]     fwd_data_q, mem_rd_q, hold_q, fwd_bits, rd_word;
  logic [31:0]     mem [MEM_WORDS];
  logic            acc, ill, complete, we;
  logic            unused_ok;
  assign unused_ok = ^{sHBURST, sHPROT, sHTRANS[0]};
  assign acc      = sHSEL & sHREADY & sHTRANS[1] & hready_q;
  assign ill      = (sHADDR[31:2] >= 30'(MEM_WORDS)) | (sHSIZE > 3'd2) |
                    ((sHSIZE == 3'd1) & sHADDR[0]) | ((sHSIZE == 3'd2) & (|sHADDR[1:0]));
  assign mask_in  = (sHSIZE == 3'd0) ? 4'b0001 << sHADDR[1:0] :
                    (sHSIZE == 3'd1) ? (sHADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign idx_in   = sHADDR[AW+1:2];
  // a pending legal data phase sitting in IDLE is the completing cycle
  assign complete = pend_q & (state_q == S_IDLE);
  assign we       = complete & wr_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (acc && ill) state_d = S_ERR1;
        else if (acc) begin
          pend_d = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
    endcase
    hready_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d  = state_d inside {S_ERR1, S_ERR2};
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pend_q     <= 1'b0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      mask_q     <= 4'd0;
      fwd_mask_q <= 4'd0;
      fwd_data_q <= 32'd0;
      hold_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      if (acc && !ill) begin
        wr_q       <= sHWRITE;
        idx_q      <= idx_in;
        mask_q     <= mask_in;
        fwd_mask_q <= (we && idx_q == idx_in) ? mask_q : 4'd0;
        fwd_data_q <= sHWDATA;
      end
      if (complete && !wr_q) hold_q <= rd_word;
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc) mem_rd_q <= mem[idx_in];
    for (int b = 0; b < 4; b++)
      if (we && mask_q[b]) mem[idx_q][8*b +: 8] <= sHWDATA[8*b +: 8];
  end
  assign fwd_bits   = {{8{fwd_mask_q[3]}}, {8{fwd_mask_q[2]}}, {8{fwd_mask_q[1]}}, {8{fwd_mask_q[0]}}};
  assign rd_word    = (mem_rd_q & ~fwd_bits) | (fwd_data_q & fwd_bits);
  assign sHRDATA    = (complete && !wr_q) ? rd_word : hold_q;
  assign sHREADYOUT = hready_q;
  assign sHRESP     = hresp_q;
endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

AHB3-Lite responder with an internal word-organised memory, used as the target for the DMA's AHB3-Lite master ports in system and block-level benches, and as a small scratch RAM in the SoC. It accepts single and burst transfers, supports byte, halfword and word accesses, inserts a configurable number of wait states, and returns the two-cycle ERROR response for illegal accesses.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; power of two, 4..65536.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase; 0..15.
- clk_i  in  1  sole clock, rising edge.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- sHSEL  in  1  slave select.
- sHADDR  in  32  byte address.
- sHWDATA  in  32  write data, valid in the data phase.
- sHRDATA  out  32  read data.
- sHWRITE  in  1  1 = write.
- sHSIZE  in  3  0 = byte, 1 = halfword, 2 = word; others illegal.
- sHBURST  in  3  ignored.
- sHPROT  in  4  ignored.
- sHTRANS  in  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
- sHREADYOUT  out  1  slave ready.
- sHREADY  in  1  bus ready (the interconnect HREADY).
- sHRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept: on a rising edge with sHSEL & sHREADY & sHTRANS[1]. On accept, latch the address, size, write flag and word index sHADDR[log2(MEM_WORDS)+1:2].
- SEQ is handled exactly like NONSEQ; the address is always taken from sHADDR. IDLE and BUSY, and non-selected cycles, get a zero-wait OKAY and have no side effects.
- Illegal access: any of the following makes a transfer illegal:
  - sHADDR[31:2] >= MEM_WORDS
  - sHSIZE > 2
  - halfword access with sHADDR[0] = 1
  - word access with sHADDR[1:0] != 0
- Data-phase FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: sHREADYOUT = 1 and sHRESP = 0. A legal accept goes to WAIT if WAIT_STATES > 0 and otherwise stays in IDLE with the data phase completing next cycle. An illegal accept goes to ERR1.
  - WAIT: sHREADYOUT = 0. A down-counter loads WAIT_STATES-1 on accept and decrements each cycle. At 0 the FSM moves to the completing cycle, with sHREADYOUT = 1.
  - ERR1: sHREADYOUT = 0, sHRESP = 1, then go to ERR2.
  - ERR2: sHREADYOUT = 1, sHRESP = 1, then go to IDLE, or to the accept target if a new transfer is accepted on that edge.
  - WAIT_STATES does not apply to error responses; they are always exactly 2 cycles.
- Write: byte-lane mask comes from the latched size and addr[1:0], little-endian (byte lane n = bits 8n+7:8n). The memory updates on the edge that ends the completing OKAY data-phase cycle, using the sHWDATA sampled on that edge. Errored writes never modify memory.
- Read: sHRDATA is driven with the full 32-bit word on the completing cycle; the master extracts the lanes it needs.
  - When no read is completing, sHRDATA holds its last value.
  - Read-after-write forwarding: a read accepted on the same edge as a completing write to the same word returns the merged new bytes.
- Pipelining: the next address phase is accepted on the same edge the current data phase completes. This gives back-to-back transfers with no idle cycle at WAIT_STATES = 0.
- Reset, asynchronous:
  - Outputs: sHREADYOUT = 1, sHRESP = 0, sHRDATA = 0.
  - FSM goes to IDLE and the wait counter clears.
  - A pending data phase is abandoned; its write is not performed.
  - Memory contents are not reset.

## Timing
- Zero wait states: address phase accepted on edge N; data phase is cycle N..N+1 with sHREADYOUT = 1. Read data is valid in that cycle; write data is committed at edge N+1.
- WAIT_STATES = W: the data phase lasts W+1 cycles, with sHREADYOUT low for the first W.
- Error: the data phase lasts exactly 2 cycles (ERR1, then ERR2).
- Read data comes from a registered memory read at the accept edge, plus the forwarding mux. There is no combinational path from sHADDR to sHRDATA.
- sHREADYOUT and sHRESP are registered FSM outputs.

## Test plan
- Word write 0xDEADBEEF to 0x10, then word read 0x10, WAIT_STATES = 0 -> read returns 0xDEADBEEF; sHREADYOUT stays 1 throughout; no idle cycle between the two transfers.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then halfword write 0xAABB to 0x22, then word read 0x20 -> 0xAABB2211.
- Write 0x12345678 to 0x40 immediately followed by a read of 0x40 (RAW forwarding) -> read returns 0x12345678 in the very next data phase.
- WAIT_STATES = 3, 4-beat INCR SEQ burst of reads from 0x0 -> each beat has sHREADYOUT low for exactly 3 cycles; data equals preloaded words 0..3.
- Word read at 0x2 (misaligned), then a write to MEM_WORDS*4 -> each gets ERR1 (sHREADYOUT = 0, sHRESP = 1) then ERR2 (sHREADYOUT = 1, sHRESP = 1); memory is unchanged; the following legal read returns OKAY.
- Deassert rst_n_i during WAIT of a write with WAIT_STATES = 2 -> sHREADYOUT = 1, sHRESP = 0 and sHRDATA = 0 immediately; the target word keeps its old value.
